// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (same as the receiver),
// the default oversampling ratio and the supported data-bit counts.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DBITS_7 = 7;
  localparam int DBITS_8 = 8;

  // Index of the final data bit for the selected word length.
  function automatic logic [2:0] last_data_idx(input logic d_num);
    return d_num ? 3'(DBITS_8 - 1) : 3'(DBITS_7 - 1);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit sample counter: counts 0..OVERSAMPLE-1 while running and flags
// the last sample of each bit period. The receiver uses the same block.
module uart_baud_cnt #(
  parameter int OVERSAMPLE = 16,
  localparam int CW = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [CW-1:0] cnt,
  output logic          end_of_bit
);

  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  // Free-run while enabled, wrapping at the end of each bit; park at 0 when stopped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign end_of_bit = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: one-word holding buffer with valid/ready, then a
// start / data (LSB first) / stop-bit serialiser on the oversampled clock.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_W     = 8
) (
  input  logic              clk_tx,
  input  logic              reset,
  input  logic              d_num,
  input  logic              stop_bits,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              Tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] PRE_LAST = CW'(OVERSAMPLE - 2);

  uart_state_e       state, state_nxt;
  logic [DATA_W-1:0] buf_data, shift_q;
  logic              buf_full, buf_dnum, buf_stop;
  logic              frame_dnum, frame_stop;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [2:0]        last_bit, last_stop;
  logic [CW-1:0]     sample_cnt;
  logic              end_of_bit, accept, load_frame, shift_en;
  logic              tx_nxt, done_nxt, buf_full_nxt;

  uart_baud_cnt #(.OVERSAMPLE(OVERSAMPLE)) u_baud (
    .clk        (clk_tx),
    .reset      (reset),
    .run        (state != IDLE),
    .cnt        (sample_cnt),
    .end_of_bit (end_of_bit)
  );

  assign accept    = tx_valid && tx_ready;
  assign last_bit  = last_data_idx(frame_dnum);
  assign last_stop = {2'b00, frame_stop};

  // Next-state and datapath control; the buffer is only ever loaded while
  // empty and only drained while full, so the two never coincide.
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    tx_nxt      = Tx;
    load_frame  = 1'b0;
    shift_en    = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (buf_full) begin
          state_nxt  = START;
          load_frame = 1'b1;
          tx_nxt     = 1'b0;
        end
      end
      START: begin
        if (end_of_bit) begin
          state_nxt   = DATA;
          tx_nxt      = shift_q[0];
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        if (end_of_bit) begin
          if (bit_idx == last_bit) begin
            state_nxt   = STOP;
            tx_nxt      = 1'b1;
            bit_idx_nxt = '0;
          end else begin
            shift_en    = 1'b1;
            tx_nxt      = shift_q[1];
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (end_of_bit) begin
          if (bit_idx == last_stop) begin
            bit_idx_nxt = '0;
            if (buf_full) begin
              state_nxt  = START;
              load_frame = 1'b1;
              tx_nxt     = 1'b0;
            end else begin
              state_nxt = IDLE;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
    done_nxt     = (state == STOP) && (bit_idx == last_stop) && (sample_cnt == PRE_LAST);
    buf_full_nxt = load_frame ? 1'b0 : (accept ? 1'b1 : buf_full);
  end

  // State register.
  always_ff @(posedge clk_tx or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Holding buffer, frame registers and registered outputs.
  always_ff @(posedge clk_tx or negedge reset) begin
    if (!reset) begin
      buf_data   <= '0;
      buf_dnum   <= 1'b0;
      buf_stop   <= 1'b0;
      buf_full   <= 1'b0;
      shift_q    <= '0;
      frame_dnum <= 1'b0;
      frame_stop <= 1'b0;
      bit_idx    <= '0;
      Tx         <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (accept) begin
        buf_data <= data_in;
        buf_dnum <= d_num;
        buf_stop <= stop_bits;
      end
      if (load_frame) begin
        shift_q    <= buf_data;
        frame_dnum <= buf_dnum;
        frame_stop <= buf_stop;
      end else if (shift_en) begin
        shift_q <= shift_q >> 1;
      end
      buf_full <= buf_full_nxt;
      tx_ready <= ~buf_full_nxt;
      bit_idx  <= bit_idx_nxt;
      Tx       <= tx_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: a driver pushes each accepted word onto a
// scoreboard queue and a line monitor pops it and checks the frame on Tx.
module tb_uart_tx_framer;
  import uart_pkg::*;

  localparam int OS = 16;

  logic       clk_tx = 1'b0;
  logic       reset = 1'b0;
  logic       d_num = 1'b1;
  logic       stop_bits = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_ready, Tx, busy, done;

  int total_checks = 0;
  int bad_checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       dnum;
    logic       stop;
    int         acc_cyc;
    bit         chk_lat;
    int         exp_gap;
  } frame_t;

  frame_t sb[$];

  bit     mon_active = 1'b0;
  frame_t cur;
  int     mon_cnt, mon_total, mon_n;
  int     bit_err, done_err, busy_err;
  int     idle_err = 0;
  int     last_end = 0;
  int     frames_done = 0;

  uart_tx_framer #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
    .clk_tx    (clk_tx),
    .reset     (reset),
    .d_num     (d_num),
    .stop_bits (stop_bits),
    .data_in   (data_in),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .Tx        (Tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_tx = ~clk_tx;

  // Edge counter used to time-stamp accepts and frame starts.
  always @(posedge clk_tx) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one word (called just after a negedge) and hold tx_valid until accepted.
  task automatic apply_stimulus(input logic [7:0] d, input logic dn, input logic st,
                                input bit lat, input int gap);
    frame_t e;
    bit ok;
    ok = 1'b0;
    e.data = d; e.dnum = dn; e.stop = st; e.chk_lat = lat; e.exp_gap = gap; e.acc_cyc = 0;
    data_in = d; d_num = dn; stop_bits = st; tx_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (tx_ready === 1'b1) begin
        e.acc_cyc = cyc + 1;
        @(posedge clk_tx);
        ok = 1'b1;
      end else begin
        @(negedge clk_tx);
      end
    end
    #1 tx_valid = 1'b0;
    if (ok) sb.push_back(e);
    else check_output("accept_timeout", 0, 1);
    @(negedge clk_tx);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      if (sb.size() == 0 && !mon_active) break;
      @(negedge clk_tx);
    end
    check_output("drain", sb.size() + int'(mon_active), 0);
    repeat (3) @(negedge clk_tx);
  endtask

  // Line monitor: detect start bits, pop the expected word, check every sample.
  always @(negedge clk_tx) begin
    if (!reset) begin
      mon_active = 1'b0;
      sb.delete();
    end else begin
      if (!mon_active) begin
        if (Tx === 1'b0) begin
          if (sb.size() == 0) begin
            check_output("unexpected_start", 1, 0);
          end else begin
            cur       = sb.pop_front();
            mon_n     = cur.dnum ? 8 : 7;
            mon_total = (1 + mon_n + (cur.stop ? 2 : 1)) * OS;
            mon_cnt   = 0;
            bit_err   = 0;
            done_err  = 0;
            busy_err  = 0;
            mon_active = 1'b1;
            if (cur.chk_lat) check_output($sformatf("latency_%02h", cur.data), cyc - cur.acc_cyc, 1);
            if (cur.exp_gap >= 0) check_output($sformatf("gap_%02h", cur.data), cyc - last_end - 1, cur.exp_gap);
          end
        end else if (done !== 1'b0 || busy !== 1'b0) begin
          idle_err++;
        end
      end
      if (mon_active) begin
        int   bit_no;
        logic exp_bit;
        bit_no = mon_cnt / OS;
        if (bit_no == 0) exp_bit = 1'b0;
        else if (bit_no <= mon_n) exp_bit = cur.data[bit_no-1];
        else exp_bit = 1'b1;
        if (Tx !== exp_bit) bit_err++;
        if (done !== (mon_cnt == mon_total - 1)) done_err++;
        if (busy !== 1'b1) busy_err++;
        if (mon_cnt % OS == OS - 1) begin
          check_output($sformatf("bad_samples_%02h_bit%0d", cur.data, bit_no), bit_err, 0);
          bit_err = 0;
        end
        mon_cnt++;
        if (mon_cnt == mon_total) begin
          check_output($sformatf("done_%02h", cur.data), done_err, 0);
          check_output($sformatf("busy_%02h", cur.data), busy_err, 0);
          frames_done++;
          last_end   = cyc;
          mon_active = 1'b0;
        end
      end
    end
  end

  initial begin
    #12;
    check_output("reset_tx", Tx, 1);
    check_output("reset_busy", busy, 0);
    check_output("reset_ready", tx_ready, 1);
    check_output("reset_done", done, 0);
    @(negedge clk_tx);
    reset = 1'b1;
    repeat (2) @(negedge clk_tx);

    $display("[TB] 8N1 0xA5");
    apply_stimulus(8'hA5, 1'b1, 1'b0, 1'b1, -1);
    wait_idle();

    $display("[TB] 7-bit two stop 0xFF and 0x80");
    apply_stimulus(8'hFF, 1'b0, 1'b1, 1'b1, -1);
    wait_idle();
    apply_stimulus(8'h80, 1'b0, 1'b0, 1'b1, -1);
    wait_idle();

    $display("[TB] back-to-back with held valid");
    apply_stimulus(8'h55, 1'b1, 1'b0, 1'b1, -1);
    repeat (40) @(negedge clk_tx);
    apply_stimulus(8'h0F, 1'b1, 1'b0, 1'b0, 0);
    check_output("ready_drop", tx_ready, 0);
    apply_stimulus(8'h3C, 1'b1, 1'b0, 1'b0, 0);
    wait_idle();

    $display("[TB] config toggled mid-frame");
    apply_stimulus(8'h96, 1'b1, 1'b0, 1'b1, -1);
    repeat (40) @(negedge clk_tx);
    d_num = 1'b0;
    stop_bits = 1'b1;
    repeat (5) @(negedge clk_tx);
    apply_stimulus(8'h6B, 1'b0, 1'b1, 1'b0, 0);
    wait_idle();

    $display("[TB] accept on the frame-end edge");
    apply_stimulus(8'hE1, 1'b1, 1'b0, 1'b1, -1);
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1) break;
      @(negedge clk_tx);
    end
    check_output("done_seen", done, 1);
    apply_stimulus(8'h1E, 1'b1, 1'b1, 1'b0, 1);
    wait_idle();

    $display("[TB] reset mid-frame");
    apply_stimulus(8'hC3, 1'b1, 1'b0, 1'b1, -1);
    for (int i = 0; i < 50; i++) begin
      if (mon_active) break;
      @(negedge clk_tx);
    end
    repeat (49) @(posedge clk_tx);
    #2 reset = 1'b0;
    #1;
    check_output("abort_tx", Tx, 1);
    check_output("abort_busy", busy, 0);
    check_output("abort_ready", tx_ready, 1);
    @(negedge clk_tx);
    check_output("abort_done", done, 0);
    repeat (3) @(negedge clk_tx);
    reset = 1'b1;
    repeat (2) @(negedge clk_tx);
    apply_stimulus(8'h3A, 1'b1, 1'b0, 1'b1, -1);
    wait_idle();

    check_output("frames_done", frames_done, 11);
    check_output("idle_outputs", idle_err, 0);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
